// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, opcode encoding and the lock FSM state type.
// The lock state type is only used when ALU_SHARE_ARB_LOCK_EN is defined.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
  localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SHR = 3'b111;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: add/sub with carry-borrow, logic ops, and 1-bit shifts.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [ALU_W-1:0] o_y,
  output logic             o_carry,
  output logic             o_zero
);

  logic [ALU_W:0] w_wide;

  always_comb begin
    w_wide  = '0;
    o_y     = '0;
    o_carry = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_wide  = {1'b0, i_a} + {1'b0, i_b};
        o_y     = w_wide[ALU_W-1:0];
        o_carry = w_wide[ALU_W];
      end
      // Bit 8 of the 9-bit difference is set exactly when a borrow occurs.
      ALU_SUB: begin
        w_wide  = {1'b0, i_a} - {1'b0, i_b};
        o_y     = w_wide[ALU_W-1:0];
        o_carry = w_wide[ALU_W];
      end
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_NOT: o_y = ~i_a;
      ALU_SHL: o_y = {i_a[ALU_W-2:0], 1'b0};
      ALU_SHR: o_y = {1'b0, i_a[ALU_W-1:1]};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request searching upward from i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int         w_j;
  logic [IDW-1:0] w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    w_pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      w_pos = IDW'(w_j);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by NREQ valid/ready requesters through a round-robin arbiter and a tagged result register.
// Define ALU_SHARE_ARB_LOCK_EN to add req_lock, letting a requester hold the ALU across several ops.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]  req_op,
`ifdef ALU_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_y,
  output logic                  rsp_carry,
  output logic                  rsp_zero
);

  logic [IDW-1:0]   r_ptr;
  logic             r_vld_p1;
  logic [IDW-1:0]   r_id_p1;
  logic [ALU_W-1:0] r_y_p1;
  logic             r_carry_p1;
  logic             r_zero_p1;

  logic [NREQ-1:0]  w_req_mask;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_can_accept;
  logic             w_xfer;
  logic             w_ptr_adv;
  logic [ALU_W-1:0] w_a;
  logic [ALU_W-1:0] w_b;
  logic [OP_W-1:0]  w_op;
  logic [ALU_W-1:0] w_y;
  logic             w_carry;
  logic             w_zero;

  assign w_can_accept = !r_vld_p1 || rsp_ready;
  assign w_xfer       = w_any && w_can_accept && !rst;
  assign req_ready    = w_gnt & {NREQ{w_can_accept && !rst}};

`ifdef ALU_SHARE_ARB_LOCK_EN
  lock_state_t    r_lk_state;
  lock_state_t    w_lk_next;
  logic [IDW-1:0] r_lk_id;

  // While locked only the owner can win; everyone else is masked out.
  assign w_req_mask = (r_lk_state == LK_LOCKED) ?
                      (req_valid & (NREQ'(1) << r_lk_id)) : req_valid;

  always_comb begin
    w_lk_next = r_lk_state;
    if (w_xfer) begin
      case (r_lk_state)
        LK_IDLE:   if (req_lock[w_idx])  w_lk_next = LK_LOCKED;
        LK_LOCKED: if (!req_lock[w_idx]) w_lk_next = LK_IDLE;
        default:   w_lk_next = LK_IDLE;
      endcase
    end
  end

  // The pointer stays frozen on the lock-entry transfer and for the whole locked run.
  assign w_ptr_adv = w_xfer && (w_lk_next == LK_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_state <= LK_IDLE;
      r_lk_id    <= '0;
    end else begin
      r_lk_state <= w_lk_next;
      if (w_xfer && (r_lk_state == LK_IDLE)) r_lk_id <= w_idx;
    end
  end
`else
  assign w_req_mask = req_valid;
  assign w_ptr_adv  = w_xfer;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req (w_req_mask),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Stage p0: operand mux from the granted requester into the shared ALU.
  assign w_a  = req_a[w_idx*ALU_W +: ALU_W];
  assign w_b  = req_b[w_idx*ALU_W +: ALU_W];
  assign w_op = req_op[w_idx*OP_W +: OP_W];

  alu u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_op    (w_op),
    .o_y     (w_y),
    .o_carry (w_carry),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
    end
  end

  // Stage p1: result register; reloads on the same edge it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_id_p1    <= '0;
      r_y_p1     <= '0;
      r_carry_p1 <= 1'b0;
      r_zero_p1  <= 1'b0;
    end else if (w_can_accept) begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_id_p1    <= w_idx;
        r_y_p1     <= w_y;
        r_carry_p1 <= w_carry;
        r_zero_p1  <= w_zero;
      end
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_id    = r_id_p1;
  assign rsp_y     = r_y_p1;
  assign rsp_carry = r_carry_p1;
  assign rsp_zero  = r_zero_p1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a result scoreboard; lock steps run when ALU_SHARE_ARB_LOCK_EN is defined.
module tb_alu_share_arb;
  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] y;
    logic       c;
    logic       z;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
`ifdef ALU_SHARE_ARB_LOCK_EN
  logic [NREQ-1:0] req_lock;
`endif
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_y;
  logic            rsp_carry;
  logic            rsp_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr = 0;
  bit   m_lock = 1'b0;
  int   m_lock_id = 0;
  int   g = -1;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
`ifdef ALU_SHARE_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero)
  );

  function automatic exp_t ref_alu(input int id, input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
    exp_t       r;
    logic [8:0] s;
    r.id = id[1:0];
    r.c  = 1'b0;
    r.y  = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[7:0]; r.c = s[8]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r.y = s[7:0]; r.c = s[8]; end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~a;
      3'd6: r.y = a << 1;
      default: r.y = a >> 1;
    endcase
    r.z = (r.y == 8'h00);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
  endtask

  // One clock: predict grant, check req_ready, update scoreboard at the edge, check outputs after it.
  task automatic cycle();
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] exp_rdy;
    bit              can;
    int              j;
    #1;
    can  = !rst && (sb.size() == 0 || rsp_ready);
    mask = req_valid;
`ifdef ALU_SHARE_ARB_LOCK_EN
    if (m_lock) mask = mask & (NREQ'(1) << m_lock_id);
`endif
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (g < 0 && mask[j]) g = j;
    end
    exp_rdy = (can && g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_ptr  = 0;
      m_lock = 1'b0;
      g      = -1;
    end else begin
      if (sb.size() > 0 && rsp_ready) void'(sb.pop_front());
      if (can && g >= 0) begin
        sb.push_back(ref_alu(g, req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g*3 +: 3]));
`ifdef ALU_SHARE_ARB_LOCK_EN
        if (m_lock) begin
          if (!req_lock[g]) begin m_lock = 1'b0; m_ptr = (g + 1) % NREQ; end
        end else if (req_lock[g]) begin
          m_lock = 1'b1; m_lock_id = g;
        end else begin
          m_ptr = (g + 1) % NREQ;
        end
`else
        m_ptr = (g + 1) % NREQ;
`endif
      end else begin
        g = -1;
      end
    end
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      check("rsp_y", 32'(rsp_y), 32'(sb[0].y));
      check("rsp_carry", 32'(rsp_carry), 32'(sb[0].c));
      check("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
    end
  endtask

  initial begin
    logic [7:0] hold_y;
    logic [1:0] hold_id;
    logic       hold_c;
    logic       hold_z;
    int         rr_ids[6];
    int         lk_ids[5];
    rr_ids = '{0, 1, 2, 3, 0, 1};
    lk_ids = '{1, 1, 1, 3, 0};

    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a = '0; req_b = '0; req_op = '0;
`ifdef ALU_SHARE_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < NREQ; i++) rand_req(i);
    cycle();
    cycle();
    check("reset_y", 32'(rsp_y), 32'h0);
    check("reset_id", 32'(rsp_id), 32'h0);
    check("reset_carry", 32'(rsp_carry), 32'h0);
    check("reset_zero", 32'(rsp_zero), 32'h0);

    rst = 1'b0;
    req_valid = '0;
    cycle();

    set_req(0, 8'hF0, 8'h20, 3'd0);
    req_valid = 4'b0001;
    cycle();
    check("add_valid", 32'(rsp_valid), 32'h1);
    check("add_id", 32'(rsp_id), 32'h0);
    check("add_y", 32'(rsp_y), 32'h10);
    check("add_carry", 32'(rsp_carry), 32'h1);
    check("add_zero", 32'(rsp_zero), 32'h0);
    req_valid = '0;
    cycle();

    set_req(2, 8'h05, 8'h05, 3'd1);
    req_valid = 4'b0100;
    cycle();
    check("sub_eq_id", 32'(rsp_id), 32'h2);
    check("sub_eq_y", 32'(rsp_y), 32'h00);
    check("sub_eq_zero", 32'(rsp_zero), 32'h1);
    check("sub_eq_carry", 32'(rsp_carry), 32'h0);
    set_req(2, 8'h03, 8'h05, 3'd1);
    cycle();
    check("sub_brw_y", 32'(rsp_y), 32'hFE);
    check("sub_brw_carry", 32'(rsp_carry), 32'h1);
    check("sub_brw_zero", 32'(rsp_zero), 32'h0);
    req_valid = '0;
    cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_id", 32'(rsp_id), 32'(rr_ids[i]));
      if (g >= 0) rand_req(g);
    end

    hold_y = rsp_y; hold_id = rsp_id; hold_c = rsp_carry; hold_z = rsp_zero;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_y", 32'(rsp_y), 32'(hold_y));
      check("bp_id", 32'(rsp_id), 32'(hold_id));
      check("bp_flags", 32'({rsp_carry, rsp_zero}), 32'({hold_c, hold_z}));
      check("bp_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_reload_valid", 32'(rsp_valid), 32'h1);
    check("bp_reload_id", 32'(rsp_id), 32'h2);

    req_valid = 4'b1110;
    rst = 1'b1;
    cycle();
    check("rst_mid_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    cycle();
    check("rst_first_id", 32'(rsp_id), 32'h1);
    req_valid = '0;
    cycle();
    cycle();

`ifdef ALU_SHARE_ARB_LOCK_EN
    rand_req(0);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    req_lock  = 4'b0010;
    req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("lock_id", 32'(rsp_id), 32'(lk_ids[i]));
      if (g >= 0) rand_req(g);
      if (i == 1) req_lock = 4'b0000;
      if (i == 2) req_valid = 4'b1001;
    end
    req_valid = '0;
    req_lock  = '0;
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
